// File: rtl/gray_palette_colorizer.sv
// Maps a 4-bit gray pixel stream to RGB444 through a 16-entry palette, VGA timing matched (2 clk).
// Optional feature macro PALETTE_WR_EN: double-buffered writable palette swapped at frame start.
module gray_palette_colorizer #(
  parameter bit VS_ACTIVE_HIGH = 1'b0,
  parameter bit INVERT         = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic [3:0]  in_gray,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [11:0] out_rgb,
  input  logic        pal_wr_valid,
  input  logic [11:0] pal_wr_data,
  output logic        pal_wr_ready,
  input  logic        pal_commit,
  output logic        pal_busy
);

  function automatic logic [11:0] ramp_entry(input logic [3:0] g);
    logic [3:0] v;
    v = INVERT ? ~g : g;
    return {v, v, v};
  endfunction

  logic        de_s1_q, hs_s1_q, vs_s1_q;
  logic [3:0]  gray_s1_q;
  logic        de_s2_q, hs_s2_q, vs_s2_q;
  logic [11:0] rgb_s2_q;
  logic [11:0] lut_rgb;

  // S1: register timing and gray
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      gray_s1_q <= 4'd0;
    end else begin
      de_s1_q   <= in_de;
      hs_s1_q   <= in_hsync;
      vs_s1_q   <= in_vsync;
      gray_s1_q <= in_gray;
    end
  end

  // S2: palette lookup, blanked outside display enable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      de_s2_q  <= 1'b0;
      hs_s2_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      rgb_s2_q <= 12'h000;
    end else begin
      de_s2_q  <= de_s1_q;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
      rgb_s2_q <= de_s1_q ? lut_rgb : 12'h000;
    end
  end

  assign out_de    = de_s2_q;
  assign out_hsync = hs_s2_q;
  assign out_vsync = vs_s2_q;
  assign out_rgb   = rgb_s2_q;

`ifdef PALETTE_WR_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_PEND = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        bank_sel_q, bank_sel_d;
  logic        vs_act_prev_q;
  logic [11:0] bank0_q [16];
  logic [11:0] bank1_q [16];
  logic        vs_act, frame_start, wr_fire;

  // Previous level resets to active so a lone active cycle after reset is not an edge.
  assign vs_act      = (in_vsync == VS_ACTIVE_HIGH);
  assign frame_start = vs_act & ~vs_act_prev_q;

  assign pal_wr_ready = reset_n && ((state_q == ST_IDLE) || (state_q == ST_FILL));
  assign pal_busy     = (state_q == ST_PEND);
  assign wr_fire      = pal_wr_valid && pal_wr_ready;

  assign lut_rgb = bank_sel_q ? bank1_q[gray_s1_q] : bank0_q[gray_s1_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bank_sel_d = bank_sel_q;
    case (state_q)
      ST_IDLE: if (wr_fire) begin
        ptr_d   = 4'd1;
        state_d = ST_FILL;
      end
      ST_FILL: if (wr_fire) begin
        if (ptr_q == 4'd15) state_d = ST_FULL;
        else                ptr_d   = ptr_q + 4'd1;
      end
      ST_FULL: if (pal_commit) state_d = ST_PEND;
      default: if (frame_start) begin
        bank_sel_d = ~bank_sel_q;
        ptr_d      = 4'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 4'd0;
      bank_sel_q    <= 1'b0;
      vs_act_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      bank_sel_q    <= bank_sel_d;
      vs_act_prev_q <= vs_act;
    end
  end

  // Writes always land in the bank not currently selected for lookup.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        bank0_q[i] <= ramp_entry(4'(i));
        bank1_q[i] <= 12'h000;
      end
    end else if (wr_fire) begin
      if (bank_sel_q) bank0_q[ptr_q] <= pal_wr_data;
      else            bank1_q[ptr_q] <= pal_wr_data;
    end
  end
`else
  logic unused_pal;

  assign unused_pal   = ^{pal_wr_valid, pal_wr_data, pal_commit};
  assign pal_wr_ready = 1'b0;
  assign pal_busy     = 1'b0;
  assign lut_rgb      = ramp_entry(gray_s1_q);
`endif

endmodule

// File: tb/tb_gray_palette_colorizer.sv
// Bench for gray_palette_colorizer: scoreboarded pixel path on a normal and an inverted instance,
// plus palette load/commit/swap sequences when PALETTE_WR_EN is defined.
module tb_gray_palette_colorizer;

  logic        clk;
  logic        reset_n;
  logic        in_de, in_hsync, in_vsync;
  logic [3:0]  in_gray;
  logic        out_de, out_hsync, out_vsync;
  logic [11:0] out_rgb;
  logic        pal_wr_valid, pal_commit;
  logic [11:0] pal_wr_data;
  logic        pal_wr_ready, pal_busy;
  logic        out_de2, out_hsync2, out_vsync2;
  logic [11:0] out_rgb2;
  logic        pal2_valid, pal2_commit;
  logic [11:0] pal2_data;
  logic        pal2_ready, pal2_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        de, hs, vs;
    logic [11:0] rgb, rgbi;
  } exp_t;
  exp_t sbq[$];

  logic [11:0] pal_m    [16];
  logic [11:0] pal_next [16];

  gray_palette_colorizer #(.VS_ACTIVE_HIGH(1'b0), .INVERT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_gray(in_gray), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_rgb(out_rgb), .pal_wr_valid(pal_wr_valid), .pal_wr_data(pal_wr_data),
    .pal_wr_ready(pal_wr_ready), .pal_commit(pal_commit), .pal_busy(pal_busy)
  );

  gray_palette_colorizer #(.VS_ACTIVE_HIGH(1'b0), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset_n(reset_n), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_gray(in_gray), .out_de(out_de2), .out_hsync(out_hsync2), .out_vsync(out_vsync2),
    .out_rgb(out_rgb2), .pal_wr_valid(pal2_valid), .pal_wr_data(pal2_data),
    .pal_wr_ready(pal2_ready), .pal_commit(pal2_commit), .pal_busy(pal2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the current inputs for one clock; the output seen now belongs to the pixel one step back.
  task automatic tick();
    exp_t e;
    logic [3:0] ng;
    ng     = ~in_gray;
    e.de   = in_de;
    e.hs   = in_hsync;
    e.vs   = in_vsync;
    e.rgb  = in_de ? pal_m[in_gray] : 12'h000;
    e.rgbi = in_de ? {ng, ng, ng} : 12'h000;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      chk("sync", {9'd0, out_de, out_hsync, out_vsync}, {9'd0, e.de, e.hs, e.vs});
      chk("rgb", out_rgb, e.rgb);
      chk("sync_inv", {9'd0, out_de2, out_hsync2, out_vsync2}, {9'd0, e.de, e.hs, e.vs});
      chk("rgb_inv", out_rgb2, e.rgbi);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1; in_gray = 4'd0;
    pal_wr_valid = 1'b0; pal_wr_data = 12'h000; pal_commit = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out", {out_de, out_hsync, out_vsync, 9'd0}, 12'h000);
    chk("rst_rgb", out_rgb, 12'h000);
    chk("rst_ready_busy", {10'd0, pal_wr_ready, pal_busy}, 12'h000);
    reset_n = 1'b1;
    set_ramp();
  endtask

  task automatic stream16();
    for (int g = 0; g < 16; g++) begin
      in_de = 1'b1; in_gray = 4'(g);
      tick();
    end
    in_de = 1'b0; in_gray = 4'd9;
    tick();
    tick();
  endtask

  task automatic pal_write(input logic [11:0] data, input logic exp_ready);
    pal_wr_valid = 1'b1;
    pal_wr_data  = data;
    in_de = 1'b1; in_gray = data[3:0];
    chk("wr_ready", {11'd0, pal_wr_ready}, {11'd0, exp_ready});
    tick();
    pal_wr_valid = 1'b0;
  endtask

  // Falling edge of active-low vsync; the new palette is visible from this pixel slot onward.
  task automatic frame_pulse(input logic swap);
    in_de = 1'b0; in_vsync = 1'b0;
    if (swap) for (int i = 0; i < 16; i++) pal_m[i] = pal_next[i];
    tick();
    in_vsync = 1'b1;
    tick();
  endtask

  initial begin
    pal2_valid = 1'b0; pal2_commit = 1'b0; pal2_data = 12'h000;
    do_reset();

    // Ramp, then blanking with a nonzero gray
    stream16();
    in_de = 1'b0; in_gray = 4'hF; tick(); tick(); tick();

    // Random timing patterns
    for (int i = 0; i < 40; i++) begin
      in_de = 1'($urandom); in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      in_gray = 4'($urandom);
      tick();
    end
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1;
    tick(); tick();

`ifdef PALETTE_WR_EN
    // Full load, overflow write, mid-frame commit
    for (int i = 0; i < 16; i++) begin
      pal_write(12'hF00 + 12'(i), 1'b1);
      pal_next[i] = 12'hF00 + 12'(i);
    end
    pal_write(12'hABC, 1'b0);
    pal_commit = 1'b1; in_de = 1'b0; tick(); pal_commit = 1'b0;
    chk("busy_after_commit", {11'd0, pal_busy}, 12'h001);
    chk("ready_in_pend", {11'd0, pal_wr_ready}, 12'h000);
    stream16();
    frame_pulse(1'b1);
    chk("busy_after_swap", {11'd0, pal_busy}, 12'h000);
    chk("ready_after_swap", {11'd0, pal_wr_ready}, 12'h001);
    stream16();

    // Early commit ignored; commit coincident with frame start waits a frame
    for (int i = 0; i < 8; i++) begin
      pal_write(12'h0A0 + 12'(i), 1'b1);
      pal_next[i] = 12'h0A0 + 12'(i);
    end
    pal_commit = 1'b1; in_de = 1'b0; tick(); pal_commit = 1'b0;
    chk("busy_partial", {11'd0, pal_busy}, 12'h000);
    stream16();
    for (int i = 8; i < 16; i++) begin
      pal_write(12'h0A0 + 12'(i), 1'b1);
      pal_next[i] = 12'h0A0 + 12'(i);
    end
    chk("ready_full", {11'd0, pal_wr_ready}, 12'h000);
    pal_commit = 1'b1; in_de = 1'b0; in_vsync = 1'b0; tick(); pal_commit = 1'b0;
    chk("busy_coincident", {11'd0, pal_busy}, 12'h001);
    in_vsync = 1'b1; tick();
    stream16();
    frame_pulse(1'b1);
    chk("busy_next_frame", {11'd0, pal_busy}, 12'h000);
    stream16();

    // Reset while pending
    for (int i = 0; i < 16; i++) pal_write(12'h5B0 + 12'(i), 1'b1);
    pal_commit = 1'b1; in_de = 1'b0; tick(); pal_commit = 1'b0;
    chk("busy_pend", {11'd0, pal_busy}, 12'h001);
    do_reset();
    chk("ready_post_rst", {11'd0, pal_wr_ready}, 12'h001);
    chk("busy_post_rst", {11'd0, pal_busy}, 12'h000);
    stream16();
    frame_pulse(1'b0);
    stream16();
`else
    // Write strobes on the fixed-ROM build have no effect
    pal_wr_valid = 1'b1; pal_wr_data = 12'h123; pal_commit = 1'b1;
    pal2_valid = 1'b1; pal2_data = 12'h456; pal2_commit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_de = 1'b1; in_gray = 4'd3;
      chk("ready_fixed", {10'd0, pal_wr_ready, pal2_ready}, 12'h000);
      chk("busy_fixed", {10'd0, pal_busy, pal2_busy}, 12'h000);
      tick();
    end
    chk("inv_gray3", out_rgb2, 12'hCCC);
    frame_pulse(1'b0);
    stream16();
    pal_wr_valid = 1'b0; pal_commit = 1'b0;
    pal2_valid = 1'b0; pal2_commit = 1'b0;
    do_reset();
    stream16();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
